dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the processor datapath and main data memory.
- Serves byte loads and stores from the ALU-addressed load/store path.
- Load data feeds the register-file write-back mux (register-file IN port).
- Stalls the CPU through BUSYWAIT while it refills or evicts 4-byte blocks over a 32-bit memory interface.

---
 rtl/dcache_ctrl.sv | 108 ++++++++++
 tb/tb_dcache_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0] data_arr [8];
  logic [2:0]  tag_arr  [8];
  logic [7:0]  valid;
  logic [7:0]  dirty;

  logic [2:0]  tag;
  logic [2:0]  index;
  logic [1:0]  offset;
  logic [31:0] block;
  logic [7:0]  sel_byte;
  logic        hit;
  logic        request;
  logic        first_cycle;
  logic        mem_done;

  assign tag      = ADDRESS[7:5];
  assign index    = ADDRESS[4:2];
  assign offset   = ADDRESS[1:0];
  assign block    = data_arr[index];
  assign sel_byte = block[{offset, 3'b000} +: 8];
  assign hit      = valid[index] && (tag_arr[index] == tag);
  assign request  = READ || WRITE;

  // Memory busy is not yet meaningful on the first cycle of a strobe.
  assign mem_done = !first_cycle && !MEM_BUSYWAIT;

  assign READDATA = READ ? sel_byte : 8'h00;
  assign BUSYWAIT = request && !((state == IDLE) && hit);

  always_comb begin
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    case (state)
      WRITEBACK: begin
        MEM_ADDRESS   = {tag_arr[index], index};
        MEM_WRITEDATA = block;
      end
      ALLOCATE: MEM_ADDRESS = ADDRESS[7:2];
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (request && !hit)
          next_state = (valid[index] && dirty[index]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: if (mem_done) next_state = ALLOCATE;
      ALLOCATE:  if (mem_done) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      valid       <= 8'd0;
      dirty       <= 8'd0;
      first_cycle <= 1'b0;
      MEM_READ    <= 1'b0;
      MEM_WRITE   <= 1'b0;
    end else begin
      state       <= next_state;
      first_cycle <= (next_state != state);
      MEM_READ    <= (next_state == ALLOCATE);
      MEM_WRITE   <= (next_state == WRITEBACK);
      if ((state == IDLE) && WRITE && hit) begin
        data_arr[index][{offset, 3'b000} +: 8] <= WRITEDATA;
        dirty[index] <= 1'b1;
      end else if ((state == ALLOCATE) && mem_done) begin
        data_arr[index] <= MEM_READDATA;
        tag_arr[index]  <= tag;
        valid[index]    <= 1'b1;
        dirty[index]    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  localparam int LAT = 3;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  logic [31:0] mem [64];
  logic [1:0]  prev_strobe;
  int          cnt;
  int          total;
  int          bad;

  dcache_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign MEM_READDATA = mem[MEM_ADDRESS];

  // Memory holds busy for LAT cycles of each unchanged strobe, then completes.
  always @(posedge CLK) begin
    #1;
    if ({MEM_READ, MEM_WRITE} != 2'b00 && {MEM_READ, MEM_WRITE} == prev_strobe)
      cnt = cnt + 1;
    else
      cnt = 0;
    prev_strobe  = {MEM_READ, MEM_WRITE};
    MEM_BUSYWAIT = (prev_strobe != 2'b00) && (cnt < LAT);
    if (MEM_WRITE && cnt == LAT) mem[MEM_ADDRESS] = MEM_WRITEDATA;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                        output int stalls, output logic [7:0] rdata, output logic [5:0] ra,
                        output logic [5:0] wa, output logic [31:0] wdat,
                        output logic saw_wr, output logic both);
    @(negedge CLK);
    READ = !wr; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    #1;
    stalls = 0; saw_wr = 0; both = 0; ra = 0; wa = 0; wdat = 0;
    while (BUSYWAIT && stalls < 50) begin
      stalls++;
      @(negedge CLK);
      if (MEM_READ) ra = MEM_ADDRESS;
      if (MEM_WRITE) begin
        saw_wr = 1; wa = MEM_ADDRESS; wdat = MEM_WRITEDATA;
      end
      if (MEM_READ && MEM_WRITE) both = 1;
    end
    rdata = READDATA;
    @(posedge CLK);
    #2;
    READ = 0; WRITE = 0;
  endtask

  int          st;
  logic [7:0]  rd;
  logic [5:0]  ra;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic        sw;
  logic        bo;
  logic [7:0]  idle_addrs [5];

  initial begin
    total = 0; bad = 0; cnt = 0; prev_strobe = 2'b00; MEM_BUSYWAIT = 1'b0;
    RESET = 0; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[6'h09] = 32'hDDCCBBAA;
    mem[6'h11] = 32'h44332211;
    mem[6'h00] = 32'h77665544;
    mem[6'h08] = 32'hA3A2A1A0;
    mem[6'h1B] = 32'h0D0C0B0A;
    idle_addrs[0] = 8'h00; idle_addrs[1] = 8'h25; idle_addrs[2] = 8'h45;
    idle_addrs[3] = 8'hFF; idle_addrs[4] = 8'h7E;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_busywait", BUSYWAIT, 0);
    check_eq("rst_readdata", READDATA, 0);
    check_eq("rst_mem_read", MEM_READ, 0);
    check_eq("rst_mem_write", MEM_WRITE, 0);
    check_eq("rst_mem_addr", MEM_ADDRESS, 0);
    check_eq("rst_mem_wdata", MEM_WRITEDATA, 0);
    RESET = 1;

    access(0, 8'h25, 8'h00, st, rd, ra, wa, wd, sw, bo);
    check_eq("s1_stalls", st, 5);
    check_eq("s1_rdata", rd, 8'hBB);
    check_eq("s1_mem_addr", ra, 6'h09);
    check_eq("s1_no_wb", sw, 0);

    access(1, 8'h26, 8'h5A, st, rd, ra, wa, wd, sw, bo);
    check_eq("s2_wr_stalls", st, 0);
    access(0, 8'h26, 8'h00, st, rd, ra, wa, wd, sw, bo);
    check_eq("s2_rd_stalls", st, 0);
    check_eq("s2_rdata", rd, 8'h5A);

    access(0, 8'h45, 8'h00, st, rd, ra, wa, wd, sw, bo);
    check_eq("s3_stalls", st, 9);
    check_eq("s3_saw_wb", sw, 1);
    check_eq("s3_wb_addr", wa, 6'h09);
    check_eq("s3_wb_data", wd, 32'hDD5ABBAA);
    check_eq("s3_alloc_addr", ra, 6'h11);
    check_eq("s3_both_strobes", bo, 0);
    check_eq("s3_rdata", rd, 8'h22);

    access(0, 8'h00, 8'h00, st, rd, ra, wa, wd, sw, bo);
    check_eq("s4a_stalls", st, 5);
    check_eq("s4a_rdata", rd, 8'h44);
    access(0, 8'h20, 8'h00, st, rd, ra, wa, wd, sw, bo);
    check_eq("s4b_stalls", st, 5);
    check_eq("s4b_no_wb", sw, 0);
    check_eq("s4b_alloc_addr", ra, 6'h08);
    check_eq("s4b_rdata", rd, 8'hA0);

    access(1, 8'h46, 8'h77, st, rd, ra, wa, wd, sw, bo);
    check_eq("s5_dirty_wr_stalls", st, 0);
    @(negedge CLK);
    READ = 1; ADDRESS = 8'h6D;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("s5_mid_mem_read", MEM_READ, 1);
    check_eq("s5_mid_mem_addr", MEM_ADDRESS, 6'h1B);
    RESET = 0; READ = 0;
    @(negedge CLK);
    check_eq("s5_rst_mem_read", MEM_READ, 0);
    check_eq("s5_rst_mem_write", MEM_WRITE, 0);
    check_eq("s5_rst_busywait", BUSYWAIT, 0);
    RESET = 1;
    access(0, 8'h6D, 8'h00, st, rd, ra, wa, wd, sw, bo);
    check_eq("s5_refetch_stalls", st, 5);
    check_eq("s5_refetch_rdata", rd, 8'h0B);
    access(0, 8'h20, 8'h00, st, rd, ra, wa, wd, sw, bo);
    check_eq("s5_valid_cleared", st, 5);
    access(0, 8'h45, 8'h00, st, rd, ra, wa, wd, sw, bo);
    check_eq("s5_dirty_cleared_stalls", st, 5);
    check_eq("s5_dirty_cleared_no_wb", sw, 0);
    check_eq("s5_dirty_discarded", rd, 8'h22);

    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      ADDRESS = idle_addrs[i];
      #1;
      check_eq("s6_busywait", BUSYWAIT, 0);
      check_eq("s6_readdata", READDATA, 0);
      check_eq("s6_mem_read", MEM_READ, 0);
      check_eq("s6_mem_write", MEM_WRITE, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
